// File: rtl/pipe_pkg.sv
// Shared constants for the 5-stage RISC-V pipeline registers.
package pipe_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RV_NOP   = 32'h0000_0013;

  // Per-boundary payload widths
  localparam int unsigned IF_ID_W  = 2 * XLEN;          // {PC, Inst}
  localparam int unsigned ID_EX_W  = 4 * XLEN + 16;     // {PC, rs1, rs2, imm, ctrl}
  localparam int unsigned EX_MEM_W = 3 * XLEN + 8;      // {alu, store data, pc4, ctrl}
  localparam int unsigned MEM_WB_W = 2 * XLEN + 8;      // {result, pc4, ctrl}

  // Bubble for the IF/ID boundary: PC cleared, instruction is a NOP
  function automatic logic [IF_ID_W-1:0] if_id_bubble();
    return {XLEN'(0), RV_NOP};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-high reset; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: main entry plus one hidden skid entry,
// registered in_ready, synchronous flush that injects BUBBLE_VAL.
// Optional performance counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned          PAYLOAD_W  = IF_ID_W,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
);

  logic                 main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0] main_data_q,  main_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_d;

  logic acc;
  logic pop;

  // Handshakes; in_ready is a direct copy of a flop so upstream sees no comb path
  assign acc = in_valid & ~skid_valid_q;
  assign pop = main_valid_q & out_ready;

  // Next-state: flush first, then the main/skid occupancy table
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = BUBBLE_VAL;
    end else if (!main_valid_q) begin
      if (acc) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end
    end else if (pop) begin
      if (skid_valid_q) begin
        // Older skid entry moves up; in_ready was low so nothing was accepted
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (!skid_valid_q && acc) begin
      // Stalled with room in the skid: park the younger entry there
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Storage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= BUBBLE_VAL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= BUBBLE_VAL;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = main_valid_q & ~out_ready;
  assign flush_inc = flush & (main_valid_q | skid_valid_q);

  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (perf_stall_cnt)
  );

  sat_counter #(.W(32)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (IF/ID configuration).
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int unsigned W = IF_ID_W;
  localparam logic [W-1:0] BUB = {32'h0000_0000, RV_NOP};

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_flush_cnt;

  int checks;
  int failures;

  pipe_stage_elastic #(
    .PAYLOAD_W  (W),
    .BUBBLE_VAL (BUB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_data", out_data, BUB);
    chk("rst_stall_cnt", W'(perf_stall_cnt), W'(0));
    chk("rst_flush_cnt", W'(perf_flush_cnt), W'(0));
    // Fill both entries, then reset mid-cycle without a clock edge
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(64'hAAAA);
    step();
    in_data = W'(64'hBBBB);
    step();
    in_valid = 1'b0;
    chk("full_in_ready", W'(in_ready), W'(0));
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", W'(out_valid), W'(0));
    chk("async_in_ready", W'(in_ready), W'(1));
    chk("async_out_data", out_data, BUB);
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = W'(i);
      step();
      chk("stream_data", out_data, W'(i));
      chk("stream_valid", W'(out_valid), W'(1));
      chk("stream_in_ready", W'(in_ready), W'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", W'(out_valid), W'(0));
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(64'hA);
    step();
    chk("stall_a_data", out_data, W'(64'hA));
    chk("stall_ready1", W'(in_ready), W'(1));
    in_data = W'(64'hB);
    step();
    chk("stall_hold_a", out_data, W'(64'hA));
    chk("stall_ready2", W'(in_ready), W'(0));
    in_data = W'(64'hC);
    step();
    chk("stall_hold_a2", out_data, W'(64'hA));
    chk("stall_ready3", W'(in_ready), W'(0));
    // Release: A is consumed at this edge, B moves up, C still offered
    out_ready = 1'b1;
    step();
    chk("release_b", out_data, W'(64'hB));
    chk("release_b_valid", W'(out_valid), W'(1));
    chk("release_ready", W'(in_ready), W'(1));
    step();
    chk("release_c", out_data, W'(64'hC));
    in_valid = 1'b0;
    step();
    chk("release_empty", W'(out_valid), W'(0));
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(64'h11);
    step();
    in_data = W'(64'h22);
    step();
    chk("flush_pre_ready", W'(in_ready), W'(0));
    chk("flush_pre_data", out_data, W'(64'h11));
    flush = 1'b1;
    in_data = W'(64'h33);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", W'(out_valid), W'(0));
    chk("flush_data", out_data, BUB);
    chk("flush_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_ghost", W'(out_valid), W'(0));
    end
  endtask

  task automatic test_pop_refill();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = W'(64'h44);
    step();
    chk("refill_first", out_data, W'(64'h44));
    in_data = W'(64'h55);
    step();
    chk("refill_second", out_data, W'(64'h55));
    chk("refill_valid", W'(out_valid), W'(1));
    chk("refill_skid_empty", W'(in_ready), W'(1));
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 32'd5;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(64'h66);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    // Flush of non-empty state with out_ready high: no stall counted
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = W'(64'h77);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    // Flush of an empty stage is not counted
    step();
    flush = 1'b0;
    step();
    chk("perf_stall", W'(perf_stall_cnt), W'(exp_stall));
    chk("perf_flush", W'(perf_flush_cnt), W'(exp_flush));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_pop_refill();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline-stage register for the 5-stage RISC-V core; the successor to the fixed IF/ID latch.
- Carries an arbitrary-width payload (e.g. {PC, instruction}) between stages with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready. Synchronous flush injects a bubble.
- Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with different widths.

Parameters:
- PAYLOAD_W, 64, payload width in bits (IF/ID uses {PC[31:0], Inst[31:0]}).
- BUBBLE_VAL, {PAYLOAD_W{1'b0}}, value loaded into the payload register on reset/flush. IF/ID sets the instruction field to 32'h0000_0013 (NOP).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream has a payload
- in_ready  out  1  stage can accept; registered, equals ~skid_valid
- in_data  in  PAYLOAD_W  upstream payload
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream accepts; low = stall
- out_data  out  PAYLOAD_W  payload to next stage (main register, direct)
- perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)
- perf_flush_cnt  out  32  flush-event counter (see Optional Feature)

Behaviour:
- Storage: main entry (main_valid, main_data) drives out_*; skid entry (skid_valid, skid_data) is hidden.
- Reset (async, immediate): main_valid=0, skid_valid=0, main_data=BUBBLE_VAL, skid_data=BUBBLE_VAL, in_ready=1, out_valid=0, perf counters=0.
- Transfers: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: 1 cycle, in_data accepted at edge N appears on out_data after edge N.
- Next-state table (no flush):
  - main empty: acc -> main<=in.
  - main full, pop, skid empty: acc -> main<=in, else main_valid<=0 (main_data holds its last value).
  - main full, pop, skid full: main<=skid, skid_valid<=0. acc is impossible because in_ready=0.
  - main full, no pop, skid empty: acc -> skid<=in, so in_ready goes 0 next cycle.
  - main full, no pop, skid full: hold everything.
- Throughput: 1 transfer per cycle sustained when out_ready=1. Back-to-back stall/unstall loses no data and duplicates none.
- Ordering: strictly FIFO; the skid entry is always younger than the main entry.
- flush=1 (highest priority after reset): at the next edge main_valid=0, skid_valid=0, main_data=BUBBLE_VAL.
  - An input accepted in the flush cycle is discarded; upstream is flushed by the same hazard unit.
  - A pop in the flush cycle still completes downstream; flush only affects state after the edge.
- flush with out_ready=0 and both entries full: both are dropped; in_ready=1 next cycle.
- in_data is ignored when in_valid=0. out_data is don't-care when out_valid=0, but in practice holds BUBBLE_VAL after reset/flush.
- Reset asserted mid-transfer: state clears immediately, regardless of clk.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle with out_valid & ~out_ready.
  - perf_flush_cnt increments each cycle flush=1 while main_valid|skid_valid.
  - Both saturate at 32'hFFFF_FFFF. Both clear only on reset.
- Undefined: both ports are tied to 32'd0 and no counter flops are synthesised. The port list is identical in both builds.

Decomposition:
- Shared package pipe_pkg:
  - RV_NOP = 32'h0000_0013
  - XLEN = 32
  - IF_ID_W = 2*XLEN
  - per-stage payload width constants
- Sub-module sat_counter (param W=32; inputs inc, clk, reset; output count): used twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: assert reset mid-cycle with both entries full -> immediately out_valid=0, in_ready=1, out_data=BUBBLE_VAL.
- Streaming: in_valid=1, out_ready=1, payloads 0x1..0x8 on 8 edges -> out_data 0x1..0x8 one cycle later, no gaps, in_ready always 1.
- Stall: out_ready=0 for 3 cycles while sending 0xA,0xB,0xC -> 0xA held on out_data, 0xB in skid, in_ready=0 from the 2nd edge. Release -> output order 0xA,0xB,0xC.
- Flush: both entries full (0x11, 0x22), flush=1 with in_valid=1 in_data=0x33 -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1; 0x33 never appears.
- Simultaneous pop and refill: main full, skid empty, out_ready=1, in_valid=1 -> new data in main next cycle, skid stays empty.
- Perf (PIPE_STAGE_PERF_EN): 5 stall cycles plus 2 flushes of non-empty state -> perf_stall_cnt=5, perf_flush_cnt=2. Without the macro -> both read 0.
